// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron MAC: FSM states, activation modes, widths.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam string ACT_RELU   = "relu";
    localparam string ACT_LINEAR = "linear";

    // Index width for N entries; at least one bit so single-input builds still elaborate.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width: full product plus enough growth bits for N summands.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned n);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Input-sample stream and result stream of the neuron MAC.
interface neuron_mac_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic [DATA_W-1:0] x_tdata;
    logic              x_tvalid;
    logic              x_tready;
    logic [DATA_W-1:0] a_tdata;
    logic              a_tvalid;
    logic              a_tready;

    // MAC side: consumes x, produces a.
    modport slave (
        input  x_tdata, x_tvalid,
        output x_tready,
        output a_tdata, a_tvalid,
        input  a_tready
    );

    // Producer/consumer side facing the MAC.
    modport master (
        output x_tdata, x_tvalid,
        input  x_tready,
        input  a_tdata, a_tvalid,
        output a_tready
    );

endinterface

// File: rtl/neuron_weight_ram.sv
// Weight store: one write port, one registered read port; contents survive reset.
module neuron_weight_ram #(
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AW       = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [N_INPUTS];

    // Write port; indices past the last weight are dropped.
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < N_INPUTS)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Synchronous read; out-of-range reads keep the previous data.
    always_ff @(posedge clk) begin
        if (i_re && (32'(i_raddr) < N_INPUTS)) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: bias + sum(x[i]*w[i]) in fixed point, then optional ReLU.
// Build option: define NEURON_MAC_SAT_EN to clamp out-of-range results instead of wrapping.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned FRAC_W   = 27,
    parameter string       ACT      = ACT_RELU
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic                        start,
    input  logic [DATA_W-1:0]           bias,
    input  logic                        w_we,
    input  logic [addr_w(N_INPUTS)-1:0] w_addr,
    input  logic [DATA_W-1:0]           w_data,
    neuron_mac_if.slave                 stream,
    output logic                        busy
);

    localparam int unsigned AW      = addr_w(N_INPUTS);
    localparam int unsigned ACC_W   = acc_w(DATA_W, N_INPUTS);
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam bit          RELU_EN = (ACT == ACT_RELU);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_start_d;
    logic [AW-1:0]             r_cnt;
    logic                      r_x_tready;
    logic                      r_busy;
    logic signed [PROD_W-1:0]  r_prod;
    logic                      r_prod_vld;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_a_tvalid;
    logic [DATA_W-1:0]         r_a_tdata;

    logic                      w_start_go;
    logic                      w_beat;
    logic                      w_last_beat;
    logic                      w_rd_en;
    logic [AW-1:0]             w_rd_addr;
    logic [DATA_W-1:0]         w_rdata;
    logic signed [ACC_W-1:0]   w_scaled;
    logic [DATA_W-1:0]         w_res;

    assign w_start_go  = (r_state == ST_IDLE) && start && !r_start_d;
    assign w_beat      = r_x_tready && stream.x_tvalid;
    assign w_last_beat = w_beat && (r_cnt == AW'(N_INPUTS - 1));
    // Keep the weight for the next index ready: index 0 while idle, then one ahead of each beat.
    assign w_rd_en     = (r_state == ST_IDLE) || w_beat;
    assign w_rd_addr   = (r_state == ST_IDLE) ? '0 : r_cnt + AW'(1);

    neuron_weight_ram #(
        .N_INPUTS (N_INPUTS),
        .DATA_W   (DATA_W),
        .AW       (AW)
    ) u_weight_ram (
        .clk      (s_axi_aclk),
        .i_we     (w_we),
        .i_waddr  (w_addr),
        .i_wdata  (w_data),
        .i_re     (w_rd_en),
        .i_raddr  (w_rd_addr),
        .o_rdata  (w_rdata)
    );

    // State register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start edges only matter in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start_go)                  w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_last_beat)                 w_state_nxt = ST_DRAIN;
            ST_DRAIN:                                  w_state_nxt = ST_OUT;
            ST_OUT:   if (r_a_tvalid && stream.a_tready) w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Control registers: start edge history, input index, ready and busy flags.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_start_d  <= 1'b0;
            r_cnt      <= '0;
            r_x_tready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_start_d  <= start;
            r_x_tready <= (w_state_nxt == ST_ACCUM);
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_start_go) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    // MAC pipeline: registered product, then accumulate; bias preloads the accumulator.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= w_beat;
            if (w_beat) begin
                r_prod <= PROD_W'($signed(stream.x_tdata)) * PROD_W'($signed(w_rdata));
            end
            if (w_start_go) begin
                r_acc <= ACC_W'($signed(bias)) <<< FRAC_W;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end
        end
    end

    assign w_scaled = r_acc >>> FRAC_W;

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    // Result formatting: scale back to DATA_W, handle overflow, then activation.
    always_comb begin
        w_res = '0;
`ifdef NEURON_MAC_SAT_EN
        if (w_scaled > SAT_MAX) begin
            w_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_scaled < SAT_MIN) begin
            w_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            w_res = DATA_W'(w_scaled);
        end
`else
        w_res = DATA_W'(w_scaled);
`endif
        if (RELU_EN && r_acc[ACC_W-1]) begin
            w_res = '0;
        end
    end

    // Result register: captured on the first OUT cycle, held until accepted.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_a_tvalid <= 1'b0;
            r_a_tdata  <= '0;
        end else if (r_state == ST_OUT) begin
            if (!r_a_tvalid) begin
                r_a_tvalid <= 1'b1;
                r_a_tdata  <= w_res;
            end else if (stream.a_tready) begin
                r_a_tvalid <= 1'b0;
            end
        end
    end

    assign stream.x_tready = r_x_tready;
    assign stream.a_tvalid = r_a_tvalid;
    assign stream.a_tdata  = r_a_tdata;
    assign busy            = r_busy;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a relu and a linear instance share one stimulus stream.
module tb_neuron_mac;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [15:0] w_data;
    logic [15:0] x_d;
    logic        x_v;
    logic        a_rdy;
    logic        busy_r, busy_l;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [15:0] wts [N];
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac_if #(.DATA_W(DW)) if_r ();
    neuron_mac_if #(.DATA_W(DW)) if_l ();

    assign if_r.x_tdata  = x_d;
    assign if_r.x_tvalid = x_v;
    assign if_r.a_tready = a_rdy;
    assign if_l.x_tdata  = x_d;
    assign if_l.x_tvalid = x_v;
    assign if_l.a_tready = a_rdy;

    neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(FW), .ACT("relu")) u_dut_relu (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start), .bias(bias),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .stream(if_r), .busy(busy_r));

    neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(FW), .ACT("linear")) u_dut_lin (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start), .bias(bias),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .stream(if_l), .busy(busy_l));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real-valued fixed-point sum, floor-scaled, then overflow rule and activation.
    function automatic logic [15:0] model(input logic [15:0] b, input logic [3:0][15:0] xs, input bit relu);
        longint      acc;
        longint      sc;
        logic [15:0] r;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < 4; i++) begin
            acc += longint'($signed(wts[i])) * longint'($signed(xs[i]));
        end
        sc = acc >>> 8;
`ifdef NEURON_MAC_SAT_EN
        if (sc > 32767)       r = 16'h7FFF;
        else if (sc < -32768) r = 16'h8000;
        else                  r = sc[15:0];
`else
        r = sc[15:0];
`endif
        if (relu && acc < 0) r = 16'h0000;
        return r;
    endfunction

    // Monitor: latency, hold stability and scoreboard compare for both instances.
    logic        mon_v  [2];
    logic [15:0] mon_d  [2];
    logic        mon_xr [2];
    logic        pv  [2] = '{1'b0, 1'b0};
    logic        phs [2] = '{1'b0, 1'b0};
    logic [15:0] pd  [2];
    int          last_beat [2] = '{0, 0};

    always_comb begin
        mon_v[0]  = if_r.a_tvalid;  mon_v[1]  = if_l.a_tvalid;
        mon_d[0]  = if_r.a_tdata;   mon_d[1]  = if_l.a_tdata;
        mon_xr[0] = if_r.x_tready;  mon_xr[1] = if_l.x_tready;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            string       nm;
            logic [15:0] e;
            nm = (d == 0) ? "relu" : "linear";
            if (!rst_n) begin
                pv[d]  = 1'b0;
                phs[d] = 1'b0;
            end else begin
                if (x_v && mon_xr[d]) last_beat[d] = cyc;
                if (mon_v[d] && !pv[d])
                    chk($sformatf("%s latency", nm), 32'(cyc - last_beat[d]), 32'd3);
                if (mon_v[d] && pv[d] && !phs[d])
                    chk($sformatf("%s hold data", nm), 32'(mon_d[d]), 32'(pd[d]));
                if (mon_v[d] && a_rdy) begin
                    if (d == 0 && exp_q0.size() == 0 || d == 1 && exp_q1.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL %s unexpected result: got 0x%0h, required no output", nm, mon_d[d]);
                    end else begin
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        chk($sformatf("%s result", nm), 32'(mon_d[d]), 32'(e));
                    end
                end
                pv[d]  = mon_v[d];
                pd[d]  = mon_d[d];
                phs[d] = mon_v[d] && a_rdy;
            end
        end
    end

    task automatic chk_reset();
        chk("rst relu x_tready", 32'(if_r.x_tready), 32'd0);
        chk("rst relu a_tvalid", 32'(if_r.a_tvalid), 32'd0);
        chk("rst relu a_tdata",  32'(if_r.a_tdata),  32'd0);
        chk("rst relu busy",     32'(busy_r),        32'd0);
        chk("rst lin x_tready",  32'(if_l.x_tready), 32'd0);
        chk("rst lin a_tvalid",  32'(if_l.a_tvalid), 32'd0);
        chk("rst lin a_tdata",   32'(if_l.a_tdata),  32'd0);
        chk("rst lin busy",      32'(busy_l),        32'd0);
    endtask

    task automatic write_w(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk) #1;
        w_we = 1'b1; w_addr = a; w_data = d;
        @(posedge clk) #1;
        w_we = 1'b0;
        wts[a] = d;
    endtask

    // One inference; abort_after>0 resets the design after that many beats.
    task automatic run_inf(input logic [15:0] b, input logic [3:0][15:0] xs, input bit gaps,
                           input int abort_after, input logic [15:0] er, input logic [15:0] el);
        bit ok;
        @(posedge clk) #1;
        bias  = b;
        start = 1'b1;
        if (abort_after == 0) begin
            exp_q0.push_back(er);
            exp_q1.push_back(el);
        end
        @(posedge clk) #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (abort_after != 0 && i == abort_after) begin
                x_v   = 1'b0;
                rst_n = 1'b0;
                #1 chk_reset();
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            if (gaps) begin
                x_v = 1'b0;
                @(posedge clk) #1;
            end
            x_v = 1'b1;
            x_d = xs[i];
            ok  = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (if_r.x_tready && if_l.x_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_chk++; n_fail++;
                $display("FAIL beat %0d: x_tready never high, required high within 20 cycles", i);
            end
            @(posedge clk) #1;
        end
        x_v = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!busy_r && !busy_l) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL wait idle: busy stuck 1, required 0 within 50 cycles");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] xs;
        logic [15:0]      b;
        bit               ok;

        rst_n = 1'b1; start = 1'b0; bias = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
        x_d = '0; x_v = 1'b0; a_rdy = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Unity weights and inputs: 4.0 + 0.5 bias.
        for (int i = 0; i < 4; i++) write_w(2'(i), 16'h0100);
        xs = {4{16'h0100}};
        run_inf(16'h0080, xs, 1'b0, 0, 16'h0480, 16'h0480);
        wait_idle();

        // Negative total: relu clamps to zero, linear gives -2.0.
        run_inf(16'hFA00, xs, 1'b0, 0, 16'h0000, 16'hFE00);
        wait_idle();

        // Input valid toggling every other cycle.
        run_inf(16'h0080, xs, 1'b1, 0, 16'h0480, 16'h0480);
        wait_idle();

        // Back-pressure: result held, busy high, start and weight write during OUT.
        a_rdy = 1'b0;
        run_inf(16'h0080, xs, 1'b0, 0, 16'h0480, 16'h0480);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (if_r.a_tvalid && if_l.a_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL hold: a_tvalid never high, required high within 20 cycles");
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk) #1;
            start  = (c == 2);
            w_we   = (c == 5);
            w_addr = 2'd2;
            w_data = 16'h0200;
            @(negedge clk);
            chk("hold relu busy",     32'(busy_r),        32'd1);
            chk("hold lin busy",      32'(busy_l),        32'd1);
            chk("hold relu a_tvalid", 32'(if_r.a_tvalid), 32'd1);
            chk("hold x_tready",      32'(if_r.x_tready), 32'd0);
        end
        wts[2] = 16'h0200;
        @(posedge clk) #1;
        start = 1'b0; w_we = 1'b0;
        a_rdy = 1'b1;
        wait_idle();
        repeat (3) begin
            @(negedge clk);
            chk("start ignored relu busy", 32'(busy_r), 32'd0);
            chk("start ignored lin busy",  32'(busy_l), 32'd0);
        end

        // Weight written during OUT is used next time: 1+1+2+1 = 5.0.
        run_inf(16'h0000, xs, 1'b0, 0, 16'h0500, 16'h0500);
        wait_idle();

        // Reset after two beats, then a clean run.
        run_inf(16'h0080, xs, 1'b0, 2, 16'h0000, 16'h0000);
        repeat (5) @(posedge clk);
        run_inf(16'h0080, xs, 1'b0, 0, 16'h0580, 16'h0580);
        wait_idle();

        // Large positive sum: clamps or wraps depending on build.
        for (int i = 0; i < 4; i++) write_w(2'(i), 16'h7F00);
        xs = {4{16'h7F00}};
`ifdef NEURON_MAC_SAT_EN
        run_inf(16'h0000, xs, 1'b0, 0, 16'h7FFF, 16'h7FFF);
`else
        run_inf(16'h0000, xs, 1'b0, 0, 16'h0400, 16'h0400);
`endif
        wait_idle();

        // Randomized inferences against the reference model.
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (k % 2 == 1) write_w(2'(i), 16'($urandom_range(0, 1023)) - 16'd512);
                else            write_w(2'(i), 16'($urandom));
            end
            for (int i = 0; i < 4; i++) begin
                if (k % 2 == 1) xs[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                else            xs[i] = 16'($urandom);
            end
            b = 16'($urandom);
            run_inf(b, xs, 1'($urandom_range(0, 1)), 0, model(b, xs, 1'b1), model(b, xs, 1'b0));
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("relu scoreboard drained", 32'(exp_q0.size()), 32'd0);
        chk("lin scoreboard drained",  32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
